// File: rtl/conv_pkg.sv
// Shared definitions for the 8-in / 2-out convolution engine sequencer.
// Holds the sequencer state encoding, the default engine pipeline timing
// and the engine lane counts.
package conv_pkg;

  // Sequencer states, kept as plain constants for compatibility with
  // existing code that compares against the raw encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WLOAD = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Window issue -> conv_out valid, and window issue -> bias adder stage.
  localparam int LAT_DEF      = 4;
  localparam int BIAS_DLY_DEF = 2;

  // Engine geometry: one weight set covers 8 input and 2 output channels.
  localparam int IN_LANES  = 8;
  localparam int OUT_LANES = 2;

endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: LAT-deep tag shift register that runs alongside the
// convolution engine pipeline. A tag is entered on every window issue and
// emerges LAT cycles later together with the engine result. A tap at
// stage BIAS_DLY provides the bias enable for the engine adder stage.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears all stages)
//   in_valid          window issued this cycle
//   in_first/in_last  window belongs to first / last input group
//   in_pix, in_ocp    pixel index and output pair index of the window
//   bias_tap          stage BIAS_DLY valid && first
//   out_*             stage LAT tag
module conv_tag_pipe #(
  parameter int PIX_W    = 16,
  parameter int CFG_W    = 8,
  parameter int LAT      = 4,
  parameter int BIAS_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [PIX_W-1:0] in_pix,
  input  logic [CFG_W-1:0] in_ocp,
  output logic             bias_tap,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic [PIX_W-1:0] out_pix,
  output logic [CFG_W-1:0] out_ocp
);

  logic [LAT-1:0]   v_q;
  logic [LAT-1:0]   f_q;
  logic [LAT-1:0]   l_q;
  logic [PIX_W-1:0] pix_q [LAT];
  logic [CFG_W-1:0] ocp_q [LAT];

  // Tag fields are masked with valid on entry so idle stages read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pix_q[i] <= '0;
        ocp_q[i] <= '0;
      end
    end else begin
      v_q      <= {v_q[LAT-2:0], in_valid};
      f_q      <= {f_q[LAT-2:0], in_valid & in_first};
      l_q      <= {l_q[LAT-2:0], in_valid & in_last};
      pix_q[0] <= in_valid ? in_pix : '0;
      ocp_q[0] <= in_valid ? in_ocp : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        pix_q[i] <= pix_q[i-1];
        ocp_q[i] <= ocp_q[i-1];
      end
    end
  end

  always_comb begin
    bias_tap  = v_q[BIAS_DLY-1] & f_q[BIAS_DLY-1];
    out_valid = v_q[LAT-1];
    out_first = f_q[LAT-1];
    out_last  = l_q[LAT-1];
    out_pix   = pix_q[LAT-1];
    out_ocp   = ocp_q[LAT-1];
  end

endmodule

// File: rtl/conv_2ch_sched.sv
// conv_2ch_sched: layer sequencer for the 8-input / 2-output channel
// convolution engine. Walks output-channel pairs (outer), 8-channel input
// groups (middle) and pixels (inner); requests a weight set per
// (pair, group), meters windows from the line buffer into the engine and
// tags results so the partial-sum accumulator can merge input groups.
// Ports:
//   sclk, s_rst_n           clock, async active-low reset
//   start                   pulse, latches cfg_* when idle
//   cfg_n_pix/icg/ocp       pixels per group, input groups, output pairs
//   busy, done              layer in progress / finished and drained
//   wt_req, wt_ack          weight-set handshake for wt_ocp/wt_icg
//   win_valid, win_ready    window handshake (issue = both high)
//   bias_enable             bias for group-0 windows at the adder stage
//   out_valid, acc_first,
//   acc_last, out_pix,
//   out_ocp                 result tags aligned with engine conv_out
module conv_2ch_sched
  import conv_pkg::*;
#(
  parameter int PIX_W    = 16,
  parameter int CFG_W    = 8,
  parameter int LAT      = LAT_DEF,
  parameter int BIAS_DLY = BIAS_DLY_DEF
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] cfg_n_pix,
  input  logic [CFG_W-1:0] cfg_n_icg,
  input  logic [CFG_W-1:0] cfg_n_ocp,
  output logic             busy,
  output logic             done,
  output logic             wt_req,
  input  logic             wt_ack,
  output logic [CFG_W-1:0] wt_ocp,
  output logic [CFG_W-1:0] wt_icg,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             bias_enable,
  output logic             out_valid,
  output logic             acc_first,
  output logic             acc_last,
  output logic [PIX_W-1:0] out_pix,
  output logic [CFG_W-1:0] out_ocp
);

  localparam int              DW         = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(LAT - 1);

  logic [2:0]       state;
  logic [PIX_W-1:0] n_pix_q;
  logic [CFG_W-1:0] n_icg_q;
  logic [CFG_W-1:0] n_ocp_q;
  logic [PIX_W-1:0] pix_cnt;
  logic [CFG_W-1:0] icg_cnt;
  logic [CFG_W-1:0] ocp_cnt;
  logic [DW-1:0]    drain_cnt;

  logic issue;
  logic pix_last;
  logic grp_first;
  logic grp_last;
  logic ocp_last;
  logic cfg_zero;

  always_comb begin
    win_ready = (state == ST_RUN) && (pix_cnt < n_pix_q);
    issue     = win_valid && win_ready;
    pix_last  = (pix_cnt == n_pix_q - PIX_W'(1));
    grp_first = (icg_cnt == '0);
    grp_last  = (icg_cnt == n_icg_q - CFG_W'(1));
    ocp_last  = (ocp_cnt == n_ocp_q - CFG_W'(1));
    cfg_zero  = (cfg_n_pix == '0) || (cfg_n_icg == '0) || (cfg_n_ocp == '0);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    wt_req    = (state == ST_WLOAD);
    wt_ocp    = ocp_cnt;
    wt_icg    = icg_cnt;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= ST_IDLE;
      n_pix_q   <= '0;
      n_icg_q   <= '0;
      n_ocp_q   <= '0;
      pix_cnt   <= '0;
      icg_cnt   <= '0;
      ocp_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_pix_q <= cfg_n_pix;
            n_icg_q <= cfg_n_icg;
            n_ocp_q <= cfg_n_ocp;
            pix_cnt <= '0;
            icg_cnt <= '0;
            ocp_cnt <= '0;
            // An empty layer still reports busy for one cycle, via DONE.
            state   <= cfg_zero ? ST_DONE : ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (wt_ack) begin
            pix_cnt <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            if (pix_last) begin
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Weights stay put until the last window of the group leaves
          // the engine, LAT cycles after its issue.
          if (drain_cnt == DRAIN_LAST) begin
            pix_cnt <= '0;
            if (grp_last) begin
              icg_cnt <= '0;
              if (ocp_last) begin
                state <= ST_DONE;
              end else begin
                ocp_cnt <= ocp_cnt + CFG_W'(1);
                state   <= ST_WLOAD;
              end
            end else begin
              icg_cnt <= icg_cnt + CFG_W'(1);
              state   <= ST_WLOAD;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_tag_pipe #(
    .PIX_W    (PIX_W),
    .CFG_W    (CFG_W),
    .LAT      (LAT),
    .BIAS_DLY (BIAS_DLY)
  ) u_tag_pipe (
    .clk       (sclk),
    .rst_n     (s_rst_n),
    .in_valid  (issue),
    .in_first  (grp_first),
    .in_last   (grp_last),
    .in_pix    (pix_cnt),
    .in_ocp    (ocp_cnt),
    .bias_tap  (bias_enable),
    .out_valid (out_valid),
    .out_first (acc_first),
    .out_last  (acc_last),
    .out_pix   (out_pix),
    .out_ocp   (out_ocp)
  );

endmodule
